// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the word producers, the arbiter and the UART tx core.
interface uart_tx_arbiter_if #(
    parameter int SIZE        = 8,
    parameter int DATA_LENGTH = 16,
    parameter int N_REQ       = 2
);
    logic [N_REQ-1:0]             req;
    logic [N_REQ*DATA_LENGTH-1:0] word_in;
    logic [N_REQ-1:0]             grant;
    logic                         busy;
    logic                         tx_start;
    logic [SIZE-1:0]              d_out;
    logic                         tx_done;

    modport slave  (input  req, word_in, tx_done, output grant, busy, tx_start, d_out);
    modport master (output req, word_in, tx_done, input  grant, busy, tx_start, d_out);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among N_REQ word producers;
// each granted word goes out as two bytes, LSB first.
module uart_tx_arbiter #(
    parameter int SIZE        = 8,
    parameter int DATA_LENGTH = 16,
    parameter int N_REQ       = 2
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int LGW = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, SEND_LSB, WAIT_LSB, SEND_MSB, WAIT_MSB} state_t;

    state_t                 state, state_nxt;
    logic [DATA_LENGTH-1:0] word_q, word_nxt;
    logic [LGW-1:0]         last_grant, last_nxt, winner;
    logic                   found;
    logic [N_REQ-1:0]       grant_nxt;
    logic                   tx_start_nxt;
    logic [SIZE-1:0]        d_out_nxt;
    int                     idx;

    // Scan starts one past the previous winner so nobody is granted twice
    // while another requester keeps req asserted.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        idx    = 0;
        for (int j = 1; j <= N_REQ; j++) begin
            idx = int'(last_grant) + j;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = LGW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        word_nxt     = word_q;
        last_nxt     = last_grant;
        grant_nxt    = '0;
        tx_start_nxt = 1'b0;
        d_out_nxt    = bus.d_out;
        case (state)
            IDLE: if (found) begin
                word_nxt          = bus.word_in[int'(winner)*DATA_LENGTH +: DATA_LENGTH];
                grant_nxt[winner] = 1'b1;
                last_nxt          = winner;
                state_nxt         = SEND_LSB;
            end
            SEND_LSB: begin
                d_out_nxt    = word_q[SIZE-1:0];
                tx_start_nxt = 1'b1;
                state_nxt    = WAIT_LSB;
            end
            WAIT_LSB: if (bus.tx_done) state_nxt = SEND_MSB;
            SEND_MSB: begin
                d_out_nxt    = word_q[2*SIZE-1:SIZE];
                tx_start_nxt = 1'b1;
                state_nxt    = WAIT_MSB;
            end
            WAIT_MSB: if (bus.tx_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q       <= '0;
            last_grant   <= LGW'(N_REQ-1);
            bus.grant    <= '0;
            bus.busy     <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.d_out    <= '0;
        end else begin
            word_q       <= word_nxt;
            last_grant   <= last_nxt;
            bus.grant    <= grant_nxt;
            bus.busy     <= (state_nxt != IDLE);
            bus.tx_start <= tx_start_nxt;
            bus.d_out    <= d_out_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration order, byte order, reset abort,
// stray tx_done and word latching.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.SIZE(8), .DATA_LENGTH(16), .N_REQ(2)) bus ();

    uart_tx_arbiter #(.SIZE(8), .DATA_LENGTH(16), .N_REQ(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " grant"},    32'(bus.grant),    32'h0);
        chk({tag, " busy"},     32'(bus.busy),     32'h0);
        chk({tag, " tx_start"}, 32'(bus.tx_start), 32'h0);
        chk({tag, " d_out"},    32'(bus.d_out),    32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1 chk_idle_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input logic [1:0] exp, input string tag);
        int n = 0;
        while (bus.grant == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " grant"}, 32'(bus.grant), 32'(exp));
        chk({tag, " busy"},  32'(bus.busy),  32'h1);
    endtask

    // Finds the next tx_start pulse, checks its byte and that it lasts one cycle.
    task automatic wait_start(input logic [7:0] exp, input string tag);
        int n = 0;
        while (!bus.tx_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " tx_start"}, 32'(bus.tx_start), 32'h1);
        chk({tag, " byte"},     32'(bus.d_out),    32'(exp));
        @(negedge clk);
        chk({tag, " pulse1"},   32'(bus.tx_start), 32'h0);
    endtask

    task automatic done_pulse(input int dly);
        repeat (dly - 1) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.word_in = '0;
        bus.tx_done = 1'b0;
        #2 chk_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word, LSB then MSB, busy falls after second tx_done
        bus.word_in[15:0] = 16'hA55A;
        bus.req = 2'b01;
        wait_grant(2'b01, "t1");
        bus.req = 2'b00;
        wait_start(8'h5A, "t1 lsb");
        done_pulse(10);
        wait_start(8'hA5, "t1 msb");
        done_pulse(10);
        chk("t1 busy_fall", 32'(bus.busy), 32'h0);
        repeat (3) @(negedge clk);
        chk("t1 no_regrant", 32'(bus.grant), 32'h0);
        chk("t1 idle_start", 32'(bus.tx_start), 32'h0);

        // 2: both requesting continuously, strict alternation from requester 0
        do_reset("t2 rst");
        bus.word_in = {16'h2222, 16'h1111};
        bus.req = 2'b11;
        wait_grant(2'b01, "t2 g0");
        wait_start(8'h11, "t2 w0l");
        done_pulse(4);
        wait_start(8'h11, "t2 w0m");
        done_pulse(4);
        chk("t2 gap_idle", 32'(bus.busy), 32'h0);
        wait_grant(2'b10, "t2 g1");
        wait_start(8'h22, "t2 w1l");
        done_pulse(4);
        wait_start(8'h22, "t2 w1m");
        done_pulse(4);
        wait_grant(2'b01, "t2 g2");
        bus.req = 2'b00;
        wait_start(8'h11, "t2 w2l");
        done_pulse(3);
        wait_start(8'h11, "t2 w2m");
        done_pulse(3);

        // 3: only requester 1 after reset, then both -> requester 0 next
        do_reset("t3 rst");
        bus.word_in = {16'hBEEF, 16'h1234};
        bus.req = 2'b10;
        wait_grant(2'b10, "t3 g1");
        bus.req = 2'b11;
        wait_start(8'hEF, "t3 lsb");
        done_pulse(5);
        wait_start(8'hBE, "t3 msb");
        done_pulse(5);
        wait_grant(2'b01, "t3 g0");
        bus.req = 2'b00;
        wait_start(8'h34, "t3 w0l");
        done_pulse(3);
        wait_start(8'h12, "t3 w0m");
        done_pulse(3);

        // 4: reset in WAIT_LSB aborts the word; held req restarts from LSB
        bus.word_in[15:0] = 16'hC3D4;
        bus.req = 2'b01;
        wait_grant(2'b01, "t4 g");
        wait_start(8'hD4, "t4 lsb");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_idle_outputs("t4 abort");
        repeat (3) @(negedge clk);
        chk("t4 rst_quiet", 32'(bus.tx_start), 32'h0);
        rst_n = 1'b1;
        wait_grant(2'b01, "t4 regrant");
        bus.req = 2'b00;
        wait_start(8'hD4, "t4 relsb");
        done_pulse(4);
        wait_start(8'hC3, "t4 msb");
        done_pulse(4);

        // 5: stray tx_done in IDLE and SEND_LSB must not advance the frame
        bus.word_in[15:0] = 16'h7788;
        bus.req = 2'b01;
        bus.tx_done = 1'b1;
        @(negedge clk);
        chk("t5 grant", 32'(bus.grant), 32'h1);
        bus.req = 2'b00;
        @(negedge clk);
        bus.tx_done = 1'b0;
        chk("t5 lsb_start", 32'(bus.tx_start), 32'h1);
        chk("t5 lsb_byte", 32'(bus.d_out), 32'h88);
        repeat (5) @(negedge clk);
        chk("t5 hold_start", 32'(bus.tx_start), 32'h0);
        chk("t5 hold_byte", 32'(bus.d_out), 32'h88);
        chk("t5 hold_busy", 32'(bus.busy), 32'h1);
        done_pulse(2);
        wait_start(8'h77, "t5 msb");
        done_pulse(2);
        chk("t5 end_busy", 32'(bus.busy), 32'h0);

        // 6: word_in cleared right after grant; latched word still goes out
        // (requester 1 is next in rotation after t5's grant to 0, so use it)
        bus.word_in = {16'h5566, 16'hFFFF};
        bus.req = 2'b10;
        wait_grant(2'b10, "t6 g");
        bus.req = 2'b00;
        bus.word_in = '0;
        wait_start(8'h66, "t6 lsb");
        done_pulse(6);
        wait_start(8'h55, "t6 msb");
        done_pulse(6);
        chk("t6 end_busy", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
